// File: rtl/currctrl_pkg.sv
// Shared definitions for the CurrCTRL port-2 RAM sequencer:
// record word offsets, FSM state encoding and the 16-bit saturation helper.
package currctrl_pkg;

  localparam logic [1:0] OFF_SP   = 2'd0;
  localparam logic [1:0] OFF_LIM  = 2'd1;
  localparam logic [1:0] OFF_MEAS = 2'd2;
  localparam logic [1:0] OFF_CNT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_SP,
    RD_LIM,
    RD_CNT,
    WR_MEAS,
    WR_CNT,
    DONE
  } state_t;

  // Two top bits disagree only when the value left the 16-bit range.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    logic [15:0] r;
    if (v[16] == v[15]) r = v[15:0];
    else if (v[16])     r = 16'h8000;
    else                r = 16'h7FFF;
    return r;
  endfunction

endpackage

// File: rtl/currctrl_sat_sub.sv
// Signed 16-bit subtract o_y = sat16(i_a - i_b), computed at 17 bits.
// Ports: i_a, i_b signed operands; o_y saturated difference. Combinational.
module currctrl_sat_sub
  import currctrl_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);

  logic [16:0] w_diff;

  assign w_diff = {i_a[15], i_a} - {i_b[15], i_b};
  assign o_y    = sat16(w_diff);

endmodule

// File: rtl/currctrl_ram_sequencer.sv
// Port-2 master of the CurrCTRL RAM: per start, read a coil record,
// compute the saturated current error, write back meas/err and count+1.
// Ports: clk, reset (sync, active-high); start/coil_idx/meas_current request;
// busy/done/idx_err status; setpoint_out/err_out results; ram_* port-2 bus.
// Option macro CURRCTRL_SEQ_CLAMP_EN: clamp setpoint to +/-limit.
module currctrl_ram_sequencer
  import currctrl_pkg::*;
#(
  parameter int NUM_COILS = 64,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        coil_idx,
  input  logic [15:0]       meas_current,
  output logic              busy,
  output logic              done,
  output logic              idx_err,
  output logic [15:0]       setpoint_out,
  output logic [15:0]       err_out,
  output logic [ADDR_W-1:0] ram_address2,
  output logic              ram_chipselect2,
  output logic              ram_write2,
  output logic [3:0]        ram_byteenable2,
  output logic [DATA_W-1:0] ram_writedata2,
  output logic              ram_clken2,
  input  logic [DATA_W-1:0] ram_readdata2
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_idx;
  logic [15:0] r_meas;
  logic [15:0] r_sp;
  logic [14:0] r_lim;
  logic [15:0] r_cnt;
  logic        r_idx_err;
  logic [15:0] r_sp_out;
  logic [15:0] r_err_out;

  logic        w_accept;
  logic        w_idx_bad;
  logic [15:0] w_sp_eff;
  logic        w_clamp_hit;
  logic [15:0] w_err;
  logic [15:0] w_cnt_inc;
  logic        w_unused_rd;

  function automatic logic [ADDR_W-1:0] rec_addr(
    input logic [5:0] idx,
    input logic [1:0] off
  );
    return ADDR_W'({idx, off});
  endfunction

  assign w_idx_bad = ({26'd0, coil_idx} >= 32'(NUM_COILS));
  assign w_accept  = (r_state == IDLE) && start;
  assign w_cnt_inc = r_cnt + 16'd1;

  // Only the low half of each word carries record data.
  assign w_unused_rd = ^ram_readdata2[DATA_W-1:16];

`ifdef CURRCTRL_SEQ_CLAMP_EN
  logic [15:0] w_lim_p;
  logic [15:0] w_lim_n;

  assign w_lim_p = {1'b0, r_lim};
  assign w_lim_n = 16'd0 - w_lim_p;

  always_comb begin
    w_sp_eff    = r_sp;
    w_clamp_hit = 1'b0;
    if ($signed(r_sp) > $signed(w_lim_p)) begin
      w_sp_eff    = w_lim_p;
      w_clamp_hit = 1'b1;
    end else if ($signed(r_sp) < $signed(w_lim_n)) begin
      w_sp_eff    = w_lim_n;
      w_clamp_hit = 1'b1;
    end
  end
`else
  logic w_unused_lim;

  // Limit word is still fetched so the access pattern never changes.
  assign w_unused_lim = ^r_lim;
  assign w_sp_eff     = r_sp;
  assign w_clamp_hit  = 1'b0;
`endif

  currctrl_sat_sub u_sat (
    .i_a (w_sp_eff),
    .i_b (r_meas),
    .o_y (w_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_meas    <= '0;
      r_sp      <= '0;
      r_lim     <= '0;
      r_cnt     <= '0;
      r_idx_err <= 1'b0;
      r_sp_out  <= '0;
      r_err_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx     <= coil_idx;
        r_meas    <= meas_current;
        r_idx_err <= w_idx_bad;
      end
      // Read data lags the address by one cycle.
      if (r_state == RD_LIM)  r_sp  <= ram_readdata2[15:0];
      if (r_state == RD_CNT)  r_lim <= ram_readdata2[14:0];
      if (r_state == WR_MEAS) r_cnt <= ram_readdata2[15:0];
      if (r_state == WR_CNT) begin
        r_sp_out  <= w_sp_eff;
        r_err_out <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    ram_chipselect2 = 1'b0;
    ram_write2      = 1'b0;
    ram_address2    = '0;
    ram_writedata2  = '0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = w_idx_bad ? DONE : RD_SP;
      end
      RD_SP: begin
        ram_chipselect2 = 1'b1;
        ram_address2    = rec_addr(r_idx, OFF_SP);
        w_state_nxt     = RD_LIM;
      end
      RD_LIM: begin
        ram_chipselect2 = 1'b1;
        ram_address2    = rec_addr(r_idx, OFF_LIM);
        w_state_nxt     = RD_CNT;
      end
      RD_CNT: begin
        ram_chipselect2 = 1'b1;
        ram_address2    = rec_addr(r_idx, OFF_CNT);
        w_state_nxt     = WR_MEAS;
      end
      WR_MEAS: begin
        ram_chipselect2 = 1'b1;
        ram_write2      = 1'b1;
        ram_address2    = rec_addr(r_idx, OFF_MEAS);
        ram_writedata2  = DATA_W'({w_err, r_meas});
        w_state_nxt     = WR_CNT;
      end
      WR_CNT: begin
        ram_chipselect2 = 1'b1;
        ram_write2      = 1'b1;
        ram_address2    = rec_addr(r_idx, OFF_CNT);
        ram_writedata2  = DATA_W'({15'd0, w_clamp_hit, w_cnt_inc});
        w_state_nxt     = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (r_state != IDLE) && (r_state != DONE);
  assign done = (r_state == DONE);
  assign idx_err = done && r_idx_err;
  assign setpoint_out = r_sp_out;
  assign err_out = r_err_out;
  assign ram_byteenable2 = 4'hF;
  assign ram_clken2 = 1'b1;

endmodule

// File: tb/tb_currctrl_ram_sequencer.sv
// Self-checking bench for currctrl_ram_sequencer: vector table,
// hand sequences for drop/reset corners, randomized ops vs a model.
module tb_currctrl_ram_sequencer;

`ifdef CURRCTRL_SEQ_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam int NC = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  coil_idx = '0;
  logic [15:0] meas_current = '0;
  logic        busy, done, idx_err;
  logic [15:0] setpoint_out, err_out;
  logic [7:0]  ram_address2;
  logic        ram_chipselect2, ram_write2, ram_clken2;
  logic [3:0]  ram_byteenable2;
  logic [31:0] ram_writedata2;
  logic [31:0] ram_readdata2 = '0;

  currctrl_ram_sequencer #(.NUM_COILS(NC), .ADDR_W(8), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .coil_idx        (coil_idx),
    .meas_current    (meas_current),
    .busy            (busy),
    .done            (done),
    .idx_err         (idx_err),
    .setpoint_out    (setpoint_out),
    .err_out         (err_out),
    .ram_address2    (ram_address2),
    .ram_chipselect2 (ram_chipselect2),
    .ram_write2      (ram_write2),
    .ram_byteenable2 (ram_byteenable2),
    .ram_writedata2  (ram_writedata2),
    .ram_clken2      (ram_clken2),
    .ram_readdata2   (ram_readdata2)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  int          cs_cnt = 0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_chipselect2 && ram_write2) mem[ram_address2] <= ram_writedata2;
    else if (pl_we) mem[pl_a] <= pl_d;
    ram_readdata2 <= mem[ram_address2];
    if (ram_chipselect2) cs_cnt <= cs_cnt + 1;
    if (ram_chipselect2 && ram_write2) wr_cnt <= wr_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_sp = '0;
  logic [15:0] last_err = '0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_a = a; pl_d = d; pl_we = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Behavioural model: plain integer arithmetic on the record contents.
  function automatic void ref_op(
    input logic [31:0] sp_w, input logic [31:0] lim_w,
    input logic [31:0] cnt_w, input logic [15:0] m,
    output logic [15:0] sp_o, output logic [15:0] err_o,
    output logic [31:0] mw, output logic [31:0] cw);
    int sp, lim, mv, e, c;
    bit hit;
    sp = int'($signed(sp_w[15:0]));
    lim = int'(lim_w[14:0]);
    mv = int'($signed(m));
    hit = 1'b0;
    if (CLAMP) begin
      if (sp > lim) begin sp = lim; hit = 1'b1; end
      else if (sp < -lim) begin sp = -lim; hit = 1'b1; end
    end
    e = sp - mv;
    if (e > 32767) e = 32767;
    if (e < -32768) e = -32768;
    c = (int'(cnt_w[15:0]) + 1) % 65536;
    sp_o = 16'(sp);
    err_o = 16'(e);
    mw = {err_o, m};
    cw = {15'd0, hit, 16'(c)};
  endfunction

  task automatic do_op(input logic [5:0] idx, input logic [15:0] m,
    output int lat, output logic b1, output logic ie,
    output logic [15:0] sp_o, output logic [15:0] er_o);
    int cyc;
    @(negedge clk);
    start = 1'b1; coil_idx = idx; meas_current = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    b1 = busy;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    ie = idx_err;
    sp_o = setpoint_out;
    er_o = err_out;
    @(negedge clk);
    chk("done_pulse", {95'd0, done}, 96'd0);
  endtask

  task automatic run_check(input string tag, input logic [5:0] idx,
    input logic [15:0] m, input logic [31:0] sp_w, input logic [31:0] lim_w,
    input logic [31:0] cnt_w, input logic [15:0] e_sp, input logic [15:0] e_err,
    input logic [31:0] e_mw, input logic [31:0] e_cw, input logic e_ie);
    logic [7:0] b;
    int c0, w0, lat;
    logic b1, ie;
    logic [15:0] so, eo;
    b = {idx, 2'b00};
    if (!e_ie) begin
      preload(b, sp_w);
      preload(b + 8'd1, lim_w);
      preload(b + 8'd2, 32'h5A5A_C3C3);
      preload(b + 8'd3, cnt_w);
    end
    c0 = cs_cnt; w0 = wr_cnt;
    do_op(idx, m, lat, b1, ie, so, eo);
    chk({tag, "_lat"}, 96'(lat), e_ie ? 96'd1 : 96'd6);
    chk({tag, "_idx_err"}, {95'd0, ie}, {95'd0, e_ie});
    chk({tag, "_busy1"}, {95'd0, b1}, {95'd0, !e_ie});
    chk({tag, "_sp_out"}, 96'(so), e_ie ? 96'(last_sp) : 96'(e_sp));
    chk({tag, "_err_out"}, 96'(eo), e_ie ? 96'(last_err) : 96'(e_err));
    chk({tag, "_cs_cycles"}, 96'(cs_cnt - c0), e_ie ? 96'd0 : 96'd5);
    chk({tag, "_writes"}, 96'(wr_cnt - w0), e_ie ? 96'd0 : 96'd2);
    if (!e_ie) begin
      chk({tag, "_meas_word"}, 96'(mem[b + 8'd2]), 96'(e_mw));
      chk({tag, "_cnt_word"}, 96'(mem[b + 8'd3]), 96'(e_cw));
      ref_mem[b + 8'd2] = e_mw;
      ref_mem[b + 8'd3] = e_cw;
      last_sp = e_sp;
      last_err = e_err;
    end
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [15:0] meas;
    logic [31:0] sp_w, lim_w, cnt_w;
    logic [15:0] e_sp, e_err;
    logic [31:0] e_mw, e_cw;
    logic        e_ie;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [95:0] out_vec();
    return {14'd0, busy, done, idx_err, setpoint_out, err_out, ram_address2,
            ram_chipselect2, ram_write2, ram_byteenable2, ram_writedata2,
            ram_clken2};
  endfunction

  localparam logic [95:0] RST_VEC = {14'd0, 3'b000, 16'd0, 16'd0, 8'd0,
                                     2'b00, 4'hF, 32'd0, 1'b1};

  initial begin
    int dc, w0, lat;
    logic b1, ie;
    logic [15:0] so, eo, xs, xe, m;
    logic [31:0] xm, xc, spw, limw, cntw;
    logic [5:0] idx;

    tbl[0] = '{6'd3, 16'h0100, 32'h0000_0200, 32'h0000_7FFF, 32'd5,
               16'h0200, 16'h0100, 32'h0100_0100, 32'h0000_0006, 1'b0};
    tbl[1] = '{6'd7, 16'h0000, 32'h0, 32'h0000_7FFF, 32'h0000_FFFF,
               16'h0000, 16'h0000, 32'h0, 32'h0, 1'b0};
    tbl[2] = '{6'd10, 16'h8000, 32'h0000_7FFF, 32'h0000_7FFF, 32'd0,
               16'h7FFF, 16'h7FFF, 32'h7FFF_8000, 32'h1, 1'b0};
    tbl[3] = '{6'd11, 16'h7FFF, 32'h0000_8000, 32'h0000_7FFF, 32'd0,
               CLAMP ? 16'h8001 : 16'h8000, 16'h8000, 32'h8000_7FFF,
               CLAMP ? 32'h0001_0001 : 32'h1, 1'b0};
    tbl[4] = '{6'd20, 16'h0000, 32'd1000, 32'd300, 32'd9,
               CLAMP ? 16'd300 : 16'd1000, CLAMP ? 16'd300 : 16'd1000,
               CLAMP ? 32'h012C_0000 : 32'h03E8_0000,
               CLAMP ? 32'h0001_000A : 32'h0000_000A, 1'b0};
    tbl[5] = '{6'd50, 16'h1234, 32'h0, 32'h0, 32'h0,
               16'h0, 16'h0, 32'h0, 32'h0, 1'b1};
    tbl[6] = '{6'd0, 16'h0032, 32'hFFFF_FF9C, 32'd50, 32'h0000_1234,
               CLAMP ? 16'hFFCE : 16'hFF9C, CLAMP ? 16'hFF9C : 16'hFF6A,
               CLAMP ? 32'hFF9C_0032 : 32'hFF6A_0032,
               CLAMP ? 32'h0001_1235 : 32'h0000_1235, 1'b0};
    tbl[7] = '{6'd47, 16'hFFFB, 32'd5, 32'd100, 32'd0,
               16'd5, 16'h000A, 32'h000A_FFFB, 32'h1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_held", out_vec(), RST_VEC);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_released", out_vec(), RST_VEC);

    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), tbl[i].idx, tbl[i].meas, tbl[i].sp_w,
                tbl[i].lim_w, tbl[i].cnt_w, tbl[i].e_sp, tbl[i].e_err,
                tbl[i].e_mw, tbl[i].e_cw, tbl[i].e_ie);

    // Starts during busy and during done are dropped.
    preload(8'd8, 32'd700);
    preload(8'd9, 32'd1000);
    preload(8'd11, 32'd77);
    ref_op(32'd700, 32'd1000, 32'd77, 16'd200, xs, xe, xm, xc);
    w0 = wr_cnt;
    dc = 0;
    @(negedge clk);
    start = 1'b1; coil_idx = 6'd2; meas_current = 16'd200;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) dc++;
      if (done) chk("drop_done_cycle", 96'(c), 96'd6);
      start = (c == 2 || c == 4 || c == 6);
      coil_idx = 6'd9;
    end
    start = 1'b0;
    chk("drop_done_count", 96'(dc), 96'd1);
    chk("drop_writes", 96'(wr_cnt - w0), 96'd2);
    chk("drop_cnt_word", 96'(mem[8'd11]), 96'(xc));
    ref_mem[8'd10] = xm;
    ref_mem[8'd11] = xc;
    last_sp = xs;
    last_err = xe;

    // Reset in cycle 4 aborts before the count write.
    preload(8'd20, 32'h0000_0100);
    preload(8'd21, 32'h0000_7FFF);
    preload(8'd22, 32'h1111_2222);
    preload(8'd23, 32'h0000_0042);
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; coil_idx = 6'd5; meas_current = 16'h0080;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", out_vec(), RST_VEC);
    chk("midreset_writes", 96'(wr_cnt - w0), 96'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_cnt_kept", 96'(mem[8'd23]), 96'h42);
    chk("midreset_meas_word", 96'(mem[8'd22]), 96'h0080_0080);
    ref_mem[8'd22] = 32'h0080_0080;
    last_sp = '0;
    last_err = '0;
    run_check("after_reset", 6'd5, 16'h0080, 32'h100, 32'h7FFF, 32'h42,
              16'h0100, 16'h0080, 32'h0080_0080, 32'h43, 1'b0);

    for (int k = 0; k < 150; k++) begin
      idx = 6'($urandom_range(0, 63));
      m = 16'($urandom);
      spw = $urandom;
      limw = $urandom;
      cntw = $urandom;
      case ($urandom_range(0, 5))
        0: spw[15:0] = 16'h7FFF;
        1: spw[15:0] = 16'h8000;
        2: cntw[15:0] = 16'hFFFF;
        3: limw[14:0] = 15'($urandom_range(0, 400));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) m = $urandom_range(0, 1) != 0 ? 16'h8000 : 16'h7FFF;
      ref_op(spw, limw, cntw, m, xs, xe, xm, xc);
      run_check("rand", idx, m, spw, limw, cntw, xs, xe, xm, xc, idx >= 6'(NC));
    end

    dc = 0;
    for (int a = 0; a < 256; a++)
      if (mem[a] !== ref_mem[a]) dc++;
    chk("final_mem_words_differing", 96'(dc), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
